// File: rtl/uart_pkg.sv
// Shared types and timing helpers for the UART PHY and its bit timer.
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Clock cycles per serial bit; integer division, so the baud error is the truncation.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Down-counter with synchronous load; tc is high while the count sits at zero.
// Loading N-1 therefore makes tc fire exactly N cycles after the load.
module uart_bit_timer #(
    parameter int WIDTH = 8
) (
    input  logic             S_AXI_ACLK,
    input  logic             S_AXI_ARESETN,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tc
);

    logic [WIDTH-1:0] count_reg;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign tc = (count_reg == '0);

endmodule

// File: rtl/uart_phy.sv
// 8N1 UART PHY sitting between a show-ahead TX FIFO and an RX FIFO.
// TX and RX are independent state machines, each with its own bit timer.
module uart_phy
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    output logic                  read_fifo_tx,
    input  logic                  empty_tx,
    input  logic [DATA_WIDTH-1:0] fifo_r_data_tx,
    output logic                  write_fifo_rx,
    input  logic                  full_rx,
    output logic [DATA_WIDTH-1:0] fifo_w_data_rx,
    output logic                  uart_tx,
    input  logic                  uart_rx,
    output logic                  overrun,
    output logic                  frame_err
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int TW  = $clog2(CPB);
    localparam logic [TW-1:0] BIT_LOAD  = TW'(CPB - 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CPB / 2 - 1);

    if (CPB < 4) begin : g_bad_cpb
        $error("uart_phy: CLK_FREQ/BAUD must be at least 4");
    end
    if (DATA_WIDTH < 8) begin : g_bad_width
        $error("uart_phy: DATA_WIDTH must be at least 8");
    end

    // Only the low byte of the TX head word is transmitted.
    logic unused_tx_bits;
    assign unused_tx_bits = ^{1'b0, fifo_r_data_tx};

    // ---------------- transmitter ----------------
    tx_state_t   tx_state_reg, tx_state_next;
    logic [7:0]  tx_shift_reg, tx_shift_next;
    logic [2:0]  tx_idx_reg, tx_idx_next;
    logic        uart_tx_reg, uart_tx_next;
    logic        tx_load, tx_tc;

    uart_bit_timer #(.WIDTH(TW)) u_tx_timer (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .load          (tx_load),
        .load_value    (BIT_LOAD),
        .tc            (tx_tc)
    );

    // TX state, shift register and registered line driver.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            tx_state_reg <= TX_IDLE;
            tx_shift_reg <= '0;
            tx_idx_reg   <= '0;
            uart_tx_reg  <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_shift_reg <= tx_shift_next;
            tx_idx_reg   <= tx_idx_next;
            uart_tx_reg  <= uart_tx_next;
        end
    end

    // TX next state; the line level is derived from the next state so it changes with it.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_shift_next = tx_shift_reg;
        tx_idx_next   = tx_idx_reg;
        tx_load       = 1'b0;
        read_fifo_tx  = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                if (!empty_tx) begin
                    read_fifo_tx  = 1'b1;
                    tx_shift_next = fifo_r_data_tx[7:0];
                    tx_load       = 1'b1;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                if (tx_tc) begin
                    tx_load       = 1'b1;
                    tx_state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_tc) begin
                    tx_load       = 1'b1;
                    tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                    tx_idx_next   = tx_idx_reg + 1'b1;
                    if (tx_idx_reg == 3'd7) begin
                        tx_state_next = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (tx_tc) begin
                    tx_state_next = TX_IDLE;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
        case (tx_state_next)
            TX_START: uart_tx_next = 1'b0;
            TX_DATA:  uart_tx_next = tx_shift_next[0];
            default:  uart_tx_next = 1'b1;
        endcase
    end

    assign uart_tx = uart_tx_reg;

    // ---------------- receiver ----------------
    rx_state_t   rx_state_reg, rx_state_next;
    logic [7:0]  rx_shift_reg, rx_shift_next;
    logic [2:0]  rx_idx_reg, rx_idx_next;
    logic [7:0]  rx_data_reg, rx_data_next;
    logic        write_reg, write_next;
    logic        overrun_reg, overrun_next;
    logic        frame_err_reg, frame_err_next;
    logic        rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic        rx_load, rx_tc;
    logic [TW-1:0] rx_load_value;

    uart_bit_timer #(.WIDTH(TW)) u_rx_timer (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .load          (rx_load),
        .load_value    (rx_load_value),
        .tc            (rx_tc)
    );

    // Two-flop synchronizer plus a delayed copy for falling-edge detection; all idle high.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= uart_rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    // RX state, shift register, received byte and status strobes.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rx_state_reg  <= RX_IDLE;
            rx_shift_reg  <= '0;
            rx_idx_reg    <= '0;
            rx_data_reg   <= '0;
            write_reg     <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            rx_state_reg  <= rx_state_next;
            rx_shift_reg  <= rx_shift_next;
            rx_idx_reg    <= rx_idx_next;
            rx_data_reg   <= rx_data_next;
            write_reg     <= write_next;
            overrun_reg   <= overrun_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // RX next state. A start needs a 1->0 edge, so a held-low (break) line never retriggers.
    always_comb begin
        rx_state_next  = rx_state_reg;
        rx_shift_next  = rx_shift_reg;
        rx_idx_next    = rx_idx_reg;
        rx_data_next   = rx_data_reg;
        write_next     = 1'b0;
        overrun_next   = 1'b0;
        frame_err_next = 1'b0;
        rx_load        = 1'b0;
        rx_load_value  = BIT_LOAD;
        case (rx_state_reg)
            RX_IDLE: begin
                if (rx_prev_reg && !rx_sync_reg) begin
                    rx_load       = 1'b1;
                    rx_load_value = HALF_LOAD;
                    rx_state_next = RX_START;
                end
            end
            RX_START: begin
                if (rx_tc) begin
                    if (rx_sync_reg) begin
                        rx_state_next = RX_IDLE;
                    end else begin
                        rx_load       = 1'b1;
                        rx_state_next = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (rx_tc) begin
                    rx_load       = 1'b1;
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
                    rx_idx_next   = rx_idx_reg + 1'b1;
                    if (rx_idx_reg == 3'd7) begin
                        rx_state_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_tc) begin
                    rx_state_next = RX_IDLE;
                    if (!rx_sync_reg) begin
                        frame_err_next = 1'b1;
                    end else if (full_rx) begin
                        overrun_next = 1'b1;
                    end else begin
                        write_next   = 1'b1;
                        rx_data_next = rx_shift_reg;
                    end
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    assign write_fifo_rx  = write_reg;
    assign overrun        = overrun_reg;
    assign frame_err      = frame_err_reg;
    assign fifo_w_data_rx = DATA_WIDTH'(rx_data_reg);

endmodule
